// File: rtl/pwm_sched_queue.sv
// Timed PWM duty-update queue: buffers {channel, time, value} and issues each as a
// 3-word CMD_SCHEDULE_PWM sequence shortly before its target time, never overwriting a pending schedule.
module pwm_sched_queue #(
    parameter int NPWM             = 12,
    parameter int CH_BITS          = $clog2(NPWM),
    parameter int CMD_BITS         = 8,
    parameter int CMD_SCHEDULE_PWM = 3,
    parameter int PWM_BITS         = 26,
    parameter int DEPTH            = 8,
    parameter int LEAD             = 64,
    parameter int LVL_BITS         = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         systime,
    input  logic                shutdown,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_BITS-1:0]  in_channel,
    input  logic [31:0]         in_time,
    input  logic [PWM_BITS-1:0] in_value,
    output logic [CMD_BITS-1:0] cmd,
    output logic                cmd_ready,
    output logic [31:0]         arg_data,
    input  logic                cmd_done,
    output logic [LVL_BITS-1:0] level,
    output logic                late,
    input  logic                late_clr
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int NSLOT    = 1 << CH_BITS;
    localparam logic [31:0]         LEAD_T = 32'(LEAD);
    localparam logic [CMD_BITS-1:0] CMD_T  = CMD_BITS'(CMD_SCHEDULE_PWM);
    localparam logic [LVL_BITS-1:0] FULL_T = LVL_BITS'(DEPTH);

    typedef struct packed {
        logic [CH_BITS-1:0]  channel;
        logic [31:0]         tgt_time;
        logic [PWM_BITS-1:0] value;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TIME,
        S_VALUE,
        S_WAIT
    } state_t;

    state_t state, state_nxt;

    entry_t              mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    entry_t              head;
    logic                rdy_en;
    logic                push;
    logic                pop;
    logic                issue;
    logic                drop;

    logic [NSLOT-1:0]    pend;
    logic [31:0]         pend_time [NSLOT];
    logic [NSLOT-1:0]    pend_eff;

    logic [31:0]         delta;
    logic                too_late;
    logic                in_window;
    logic [31:0]         cur_time;
    logic [PWM_BITS-1:0] cur_value;

    // rdy_en keeps in_ready low for as long as reset is held.
    always_ff @(posedge clk) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    assign in_ready = rdy_en && (level != FULL_T) && !shutdown;
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_channel, in_time, in_value};
    end

    always_ff @(posedge clk) begin
        if (!rst_n || shutdown) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_BITS'(push) - LVL_BITS'(pop);
        end
    end

    assign head      = mem[rd_ptr];
    assign delta     = head.tgt_time - systime;
    assign too_late  = (delta < 32'd4) || (delta >= 32'hC000_0000);
    assign in_window = (delta <= LEAD_T);

    // pwm loads the schedule on the cycle systime hits pend_time, so the slot is free that same cycle.
    always_comb begin
        pend_eff = '0;
        for (int c = 0; c < NSLOT; c++) begin
            pend_eff[c] = pend[c] && (systime != pend_time[c]);
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        drop      = 1'b0;
        case (state)
            S_IDLE: begin
                if ((level != '0) && !shutdown) begin
                    if (too_late) begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end else if (in_window && !pend_eff[head.channel]) begin
                        pop       = 1'b1;
                        issue     = 1'b1;
                        state_nxt = S_TIME;
                    end
                end
            end
            S_TIME:  state_nxt = S_VALUE;
            S_VALUE: state_nxt = S_WAIT;
            S_WAIT:  if (cmd_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd       <= '0;
            cmd_ready <= 1'b0;
            arg_data  <= '0;
            cur_time  <= '0;
            cur_value <= '0;
            late      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= issue;
            if (issue) begin
                cmd       <= CMD_T;
                arg_data  <= 32'(head.channel);
                cur_time  <= head.tgt_time;
                cur_value <= head.value;
            end else if (state == S_TIME) begin
                arg_data <= cur_time;
            end else if (state == S_VALUE) begin
                arg_data <= 32'(cur_value);
            end
            if (drop)          late <= 1'b1;
            else if (late_clr) late <= 1'b0;
        end
    end

    // An issue on a channel whose pend clears this cycle re-arms it; the set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
            for (int c = 0; c < NSLOT; c++) pend_time[c] <= '0;
        end else begin
            for (int c = 0; c < NSLOT; c++) begin
                if (shutdown) begin
                    pend[c] <= 1'b0;
                end else if (issue && (head.channel == CH_BITS'(c))) begin
                    pend[c]      <= 1'b1;
                    pend_time[c] <= head.tgt_time;
                end else if (systime == pend_time[c]) begin
                    pend[c] <= 1'b0;
                end
            end
        end
    end

endmodule
